// File: rtl/mlp_argmax_reader.sv
`default_nettype none
// ============================================================================
//  Module   : mlp_argmax_reader
//  Purpose  : Reduces the MLP output layer (NUM_CLASSES packed signed scores)
//             to a predicted digit. The score bus is snapshotted on a start
//             pulse. One class is scanned per cycle with a signed compare.
//             The result is presented behind a valid/ready handshake.
//  Ports    : clk, rst_b (async, active-low)
//             start, scores[NUM_CLASSES*SCORE_W]         -- from layer-2 MAC
//             busy, start_dropped                        -- status
//             result_valid, result_ready, digit, max_score -- result channel
//             second_digit, margin                       -- MLP_ARGMAX_TOP2_EN only
//  Options  : define MLP_ARGMAX_TOP2_EN to add runner-up index and margin
//  Revision : 1.0  initial release
// ============================================================================
module mlp_argmax_reader #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 16,
    parameter int IDX_W       = 4
) (
    input  logic                           clk,
    input  logic                           rst_b,
    input  logic                           start,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    output logic                           busy,
    output logic                           start_dropped,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [IDX_W-1:0]               digit,
    output logic [SCORE_W-1:0]             max_score
`ifdef MLP_ARGMAX_TOP2_EN
    ,
    output logic [IDX_W-1:0]               second_digit,
    output logic [SCORE_W:0]               margin
`endif
);

    localparam logic [IDX_W-1:0] c_FIRST_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [SCORE_W-1:0] r_snap [NUM_CLASSES];
    logic signed [SCORE_W-1:0] r_best;
    logic        [IDX_W-1:0]   r_best_idx;
    logic        [IDX_W-1:0]   r_idx;
    logic        [IDX_W-1:0]   r_digit;
    logic        [SCORE_W-1:0] r_max_score;
    logic                      r_valid;
    logic                      r_dropped;

    logic signed [SCORE_W-1:0] w_cand;
    logic                      w_gt;
    logic                      w_last;
    logic signed [SCORE_W-1:0] w_fin_best;
    logic        [IDX_W-1:0]   w_fin_idx;

    // ------------------------------------------------------------------
    // Candidate selection and compare (shared by both build options)
    // ------------------------------------------------------------------
    assign w_cand     = r_snap[r_idx];
    // Strict greater-than keeps the lowest index on ties.
    assign w_gt       = (w_cand > r_best);
    assign w_last     = (r_idx == c_LAST_IDX);
    assign w_fin_best = w_gt ? w_cand : r_best;
    assign w_fin_idx  = w_gt ? r_idx  : r_best_idx;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)        w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_last)       w_state_nxt = ST_HOLD;
            ST_HOLD: if (result_ready) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_snap[k] <= '0;
            end
            r_best      <= '0;
            r_best_idx  <= '0;
            r_idx       <= '0;
            r_digit     <= '0;
            r_max_score <= '0;
            r_valid     <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            // Any start outside IDLE is discarded and flagged for one cycle.
            r_dropped <= start && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            r_snap[k] <= scores[k*SCORE_W +: SCORE_W];
                        end
                        // Class 0 seeds the running maximum directly from the bus.
                        r_best     <= scores[SCORE_W-1:0];
                        r_best_idx <= '0;
                        r_idx      <= c_FIRST_IDX;
                    end
                end
                ST_SCAN: begin
                    r_best     <= w_fin_best;
                    r_best_idx <= w_fin_idx;
                    r_idx      <= r_idx + c_FIRST_IDX;
                    if (w_last) begin
                        r_digit     <= w_fin_idx;
                        r_max_score <= w_fin_best;
                        r_valid     <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (result_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign start_dropped = r_dropped;
    assign result_valid  = r_valid;
    assign digit         = r_digit;
    assign max_score     = r_max_score;

`ifdef MLP_ARGMAX_TOP2_EN
    // ------------------------------------------------------------------
    // Runner-up tracking
    // ------------------------------------------------------------------
    logic signed [SCORE_W-1:0] r_second;
    logic        [IDX_W-1:0]   r_second_idx;
    logic                      r_second_valid;
    logic        [IDX_W-1:0]   r_second_digit;
    logic        [SCORE_W:0]   r_margin;

    logic                      w_sec_take;
    logic signed [SCORE_W-1:0] w_fin_second;
    logic        [IDX_W-1:0]   w_fin_second_idx;
    logic signed [SCORE_W:0]   w_margin;

    // A tie with the current best is not "greater", so it lands here,
    // which gives margin = 0 for duplicated maxima.
    assign w_sec_take       = !w_gt && (!r_second_valid || (w_cand > r_second));
    assign w_fin_second     = w_gt ? r_best     : (w_sec_take ? w_cand : r_second);
    assign w_fin_second_idx = w_gt ? r_best_idx : (w_sec_take ? r_idx  : r_second_idx);
    // One extra bit makes the full-range difference exact; it is never negative.
    assign w_margin = {w_fin_best[SCORE_W-1], w_fin_best}
                    - {w_fin_second[SCORE_W-1], w_fin_second};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_second       <= '0;
            r_second_idx   <= '0;
            r_second_valid <= 1'b0;
            r_second_digit <= '0;
            r_margin       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_second_valid <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_second       <= w_fin_second;
                    r_second_idx   <= w_fin_second_idx;
                    r_second_valid <= 1'b1;
                    if (w_last) begin
                        r_second_digit <= w_fin_second_idx;
                        r_margin       <= w_margin;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign second_digit = r_second_digit;
    assign margin       = r_margin;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mlp_argmax_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mlp_argmax_reader
//  Purpose  : Directed self-checking bench for mlp_argmax_reader. Expected
//             results are computed from the stimulus by a reference model,
//             queued at start, and popped when result_valid rises.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mlp_argmax_reader;

    localparam int NC = 10;
    localparam int SW = 16;
    localparam int IW = 4;

    logic              clk;
    logic              rst_b;
    logic              start;
    logic [NC*SW-1:0]  scores;
    logic              busy;
    logic              start_dropped;
    logic              result_valid;
    logic              result_ready;
    logic [IW-1:0]     digit;
    logic [SW-1:0]     max_score;
`ifdef MLP_ARGMAX_TOP2_EN
    logic [IW-1:0]     second_digit;
    logic [SW:0]       margin;
`endif

    mlp_argmax_reader #(
        .NUM_CLASSES (NC),
        .SCORE_W     (SW),
        .IDX_W       (IW)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .start         (start),
        .scores        (scores),
        .busy          (busy),
        .start_dropped (start_dropped),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .digit         (digit),
        .max_score     (max_score)
`ifdef MLP_ARGMAX_TOP2_EN
        ,
        .second_digit  (second_digit),
        .margin        (margin)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] d;
        logic [SW-1:0] m;
        logic [IW-1:0] d2;
        logic [SW:0]   mg;
    } exp_t;

    exp_t               sb[$];
    logic signed [SW-1:0] sc [NC];
    int                 checks;
    int                 failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_bus();
        for (int k = 0; k < NC; k++) begin
            scores[k*SW +: SW] = sc[k];
        end
    endtask

    // Reference: best = lowest index holding the maximum; runner-up = lowest
    // index holding the maximum among the remaining classes.
    function automatic exp_t model();
        exp_t e;
        int   b;
        int   s2;
        int   diff;
        b = 0;
        for (int k = 1; k < NC; k++) if (sc[k] > sc[b]) b = k;
        s2 = (b == 0) ? 1 : 0;
        for (int k = 0; k < NC; k++) if (k != b && sc[k] > sc[s2]) s2 = k;
        diff = int'(sc[b]) - int'(sc[s2]);
        e.d  = IW'(b);
        e.m  = sc[b];
        e.d2 = IW'(s2);
        e.mg = diff[SW:0];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        drive_bus();
        sb.push_back(model());
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!result_valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 9);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_digit"}, digit, e.d);
            chk({tag, "_max"}, max_score, e.m);
`ifdef MLP_ARGMAX_TOP2_EN
            chk({tag, "_second"}, second_digit, e.d2);
            chk({tag, "_margin"}, margin, e.mg);
`endif
        end
    endtask

    task automatic accept(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({tag, "_valid_clr"}, result_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_drop"}, start_dropped, 0);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_digit"}, digit, 0);
        chk({tag, "_max"}, max_score, 0);
`ifdef MLP_ARGMAX_TOP2_EN
        chk({tag, "_second"}, second_digit, 0);
        chk({tag, "_margin"}, margin, 0);
`endif
    endtask

    initial begin
        logic [IW-1:0] hd;
        logic [SW-1:0] hm;
        checks       = 0;
        failures     = 0;
        rst_b        = 1'b0;
        start        = 1'b0;
        result_ready = 1'b0;
        scores       = '0;
        for (int k = 0; k < NC; k++) sc[k] = '0;
        tick();
        tick();
        chk_zero("reset");
        rst_b = 1'b1;
        tick();

        // ready while nothing is valid has no effect
        result_ready = 1'b1;
        tick();
        tick();
        result_ready = 1'b0;
        chk("ready_idle_valid", result_valid, 0);

        // 1: mixed scores, max at index 2
        sc = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd11};
        do_start();
        chk("t1_busy_scan", busy, 1);
        wait_result("t1");
        accept("t1");

        // 2: all equal -> lowest index wins, tie lands in runner-up
        for (int k = 0; k < NC; k++) sc[k] = -16'sd4;
        do_start();
        wait_result("t2");
        accept("t2");
        chk("t2_digit_kept", digit, 0);
        chk("t2_max_kept", max_score, 16'hFFFC);

        // 3: extremes
        for (int k = 0; k < NC; k++) sc[k] = -16'sd1;
        sc[0] = -16'sd32768;
        sc[9] = 16'sd32767;
        do_start();
        wait_result("t3");
        hd = digit;
        hm = max_score;

        // 4: hold for 20 cycles, start during HOLD is dropped
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4_hold_valid", result_valid, 1);
            chk("t4_hold_busy", busy, 1);
            chk("t4_hold_digit", digit, hd);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_drop_pulse", start_dropped, 1);
        tick();
        chk("t4_drop_clear", start_dropped, 0);
        chk("t4_max_kept", max_score, hm);
        chk("t4_digit_kept", digit, hd);
        accept("t4");

        // 5: bus changes every scan cycle; start during SCAN is dropped
        for (int k = 0; k < NC; k++) sc[k] = SW'(k * 100 - 300);
        sc[6] = 16'sd2000;
        do_start();
        for (int i = 0; i < 4; i++) begin
            scores = {$urandom, $urandom, $urandom, $urandom, $urandom};
            if (i == 1) start = 1'b1;
            tick();
            start = 1'b0;
            if (i == 1) chk("t5_drop_scan", start_dropped, 1);
        end
        // remaining scan cycles are absorbed by wait_result, so account for the four above
        begin
            int   n;
            exp_t e;
            n = 4;
            while (!result_valid && n < 30) begin
                scores = {$urandom, $urandom, $urandom, $urandom, $urandom};
                tick();
                n++;
            end
            chk("t5_latency", n, 9);
            e = sb.pop_front();
            chk("t5_digit", digit, e.d);
            chk("t5_max", max_score, e.m);
`ifdef MLP_ARGMAX_TOP2_EN
            chk("t5_second", second_digit, e.d2);
            chk("t5_margin", margin, e.mg);
`endif
        end
        accept("t5");

        // 6: reset during scan cycle 4, then a fresh run
        sc = '{-16'sd7, 16'sd9, 16'sd100, -16'sd50, 16'sd99, 16'sd3, 16'sd100, 16'sd0, 16'sd1, 16'sd2};
        do_start();
        for (int i = 0; i < 3; i++) tick();
        #1;
        rst_b = 1'b0;
        #1;
        sb.delete();
        chk_zero("t6_rst");
        tick();
        rst_b = 1'b1;
        tick();
        sc = '{16'sd1, 16'sd2, 16'sd3, -16'sd4, 16'sd5, 16'sd6, 16'sd77, 16'sd8, 16'sd77, -16'sd10};
        do_start();
        wait_result("t6");
        accept("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
